// File: rtl/id_hazard_sequencer.sv
// rtl/id_hazard_sequencer.sv - ID-stage hazard sequencer: stall/bubble/flush control with perf counters
//
// Purpose: decides per cycle whether to hold PC and IF/ID, inject a bubble into
// ID/EX, or flush IF/ID on a taken branch resolved in ID. Multi-cycle stalls
// (branch after load) are carried by a two-state FSM.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_*                          IF/ID instruction fields and branch info
//   ex_reg_write/ex_mem_read/ex_dst   ID/EX control bits and destination
//   mem_mem_read/mem_dst          EX/MEM load bit and destination
//   ext_stall                     external freeze request
//   pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, pc_sel_branch
//                                 combinational pipeline control outputs
//   stall_cnt, flush_cnt          saturating performance counters

module id_hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_is_branch,
    input  logic             branch_taken,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_dst,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_dst,
    input  logic             ext_stall,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             pc_sel_branch,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       rs_live, rt_live;
    logic       ex_match, mem_match;
    logic [1:0] need_n;

    // A source only counts when the instruction is real, actually reads it,
    // and it is not $zero (writes to r0 are discarded, so no dependency).
    assign rs_live   = id_valid && id_uses_rs && (id_rs != 5'd0);
    assign rt_live   = id_valid && id_uses_rt && (id_rt != 5'd0);
    assign ex_match  = (rs_live && (id_rs == ex_dst))  || (rt_live && (id_rt == ex_dst));
    assign mem_match = (rs_live && (id_rs == mem_dst)) || (rt_live && (id_rt == mem_dst));

    // Required stall count. Branches compare in ID, so they also wait on ALU
    // results in EX and on loads still in MEM; ordinary ops rely on forwarding
    // and only wait on a load in EX. Rules combine by maximum, never by sum.
    always_comb begin
        need_n = 2'd0;
        if (!id_is_branch) begin
            if (ex_mem_read && ex_match) begin
                need_n = 2'd1;
            end
        end else begin
            if (mem_mem_read && mem_match) begin
                need_n = 2'd1;
            end
            if (ex_reg_write && ex_match) begin
                need_n = ex_mem_read ? 2'd2 : 2'd1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        pc_hold       = 1'b0;
        ifid_hold     = 1'b0;
        idex_hold     = 1'b0;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        pc_sel_branch = 1'b0;

        if (rst) begin
            state_d = RUN;
            rem_d   = 2'd0;
        end else if (ext_stall) begin
            // Full freeze: nothing advances, FSM and rem hold their values.
            pc_hold   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (need_n != 2'd0) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                        rem_d       = need_n - 2'd1;
                        state_d     = (need_n > 2'd1) ? STALL : RUN;
                    end else if (id_is_branch && branch_taken) begin
                        pc_sel_branch = 1'b1;
                        ifid_flush    = 1'b1;
                    end
                end
                STALL: begin
                    // Hazards are not re-evaluated here; the count was fixed
                    // when the stall started.
                    pc_hold     = 1'b1;
                    ifid_hold   = 1'b1;
                    idex_bubble = 1'b1;
                    rem_d       = rem_q - 2'd1;
                    if (rem_q <= 2'd1) begin
                        rem_d   = 2'd0;
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            rem_q       <= 2'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (idex_bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_id_hazard_sequencer.sv
// tb/tb_id_hazard_sequencer.sv - self-checking bench for id_hazard_sequencer

module tb_id_hazard_sequencer;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    // Expected output order: {pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, pc_sel_branch}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] STL  = 6'b110100;
    localparam logic [5:0] EXT  = 6'b111000;
    localparam logic [5:0] FLS  = 6'b000011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, id_valid, id_uses_rs, id_uses_rt, id_is_branch, branch_taken;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic ex_reg_write, ex_mem_read, mem_mem_read, ext_stall;
    logic pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, pc_sel_branch;
    logic [W-1:0] stall_cnt, flush_cnt;

    id_hazard_sequencer #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_is_branch(id_is_branch),
        .branch_taken(branch_taken), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_dst(ex_dst), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst), .ext_stall(ext_stall),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .pc_sel_branch(pc_sel_branch),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       rst, ext, valid;
        logic [4:0] rs, rt;
        logic       urs, urt, br, tk, exw, exr;
        logic [4:0] exd;
        logic       memr;
        logic [4:0] memd;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [5:0] e;
        string      nm;
    } vec_t;

    function automatic stim_t mk(input logic r, input logic x, input logic v,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt, input logic br, input logic tk,
                                 input logic exw, input logic exr, input logic [4:0] exd,
                                 input logic memr, input logic [4:0] memd);
        stim_t t;
        t.rst = r; t.ext = x; t.valid = v; t.rs = rs; t.rt = rt;
        t.urs = urs; t.urt = urt; t.br = br; t.tk = tk;
        t.exw = exw; t.exr = exr; t.exd = exd; t.memr = memr; t.memd = memd;
        return t;
    endfunction

    function automatic vec_t mv(input stim_t s, input logic [5:0] e, input string nm);
        vec_t v;
        v.s = s; v.e = e; v.nm = nm;
        return v;
    endfunction

    function automatic int sat(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    int total = 0;
    int bad   = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    logic [5:0] exp_q[$];
    string      nm_q[$];

    task automatic apply(input stim_t s);
        rst = s.rst; ext_stall = s.ext; id_valid = s.valid; id_rs = s.rs; id_rt = s.rt;
        id_uses_rs = s.urs; id_uses_rt = s.urt; id_is_branch = s.br; branch_taken = s.tk;
        ex_reg_write = s.exw; ex_mem_read = s.exr; ex_dst = s.exd;
        mem_mem_read = s.memr; mem_dst = s.memd;
    endtask

    // One clock cycle: drive after the edge, push the expectation, check at negedge.
    // Counters are registered, so they are compared against everything before this cycle.
    task automatic step(input stim_t s, input logic [5:0] e, input string nm);
        logic [5:0] got, want;
        string      n;
        @(posedge clk);
        #1;
        apply(s);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(negedge clk);
        want = exp_q.pop_front();
        n    = nm_q.pop_front();
        got  = {pc_hold, ifid_hold, idex_hold, idex_bubble, ifid_flush, pc_sel_branch};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: controls got %b want %b", n, got, want);
        end
        total++;
        if (stall_cnt !== W'(exp_stall)) begin
            bad++;
            $display("FAIL %s: stall_cnt got %0d want %0d", n, stall_cnt, exp_stall);
        end
        total++;
        if (flush_cnt !== W'(exp_flush)) begin
            bad++;
            $display("FAIL %s: flush_cnt got %0d want %0d", n, flush_cnt, exp_flush);
        end
        if (s.rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (want[2]) exp_stall = sat(exp_stall);
            if (want[1]) exp_flush = sat(exp_flush);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t  vecs[$];
        stim_t idle, lu, bal, nb_nt, nb_tk, alu1, alu2, mx;

        idle  = mk(0,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0);
        lu    = mk(0,0,1, 2,7, 1,1, 0,0, 1,1,2, 0,0);   // lw $2 in EX, add uses $2
        bal   = mk(0,0,1, 3,0, 1,0, 1,0, 1,1,3, 0,0);   // beq $3 after lw $3
        nb_nt = mk(0,0,1, 3,0, 1,0, 1,0, 0,0,0, 0,0);   // branch, no hazard, not taken
        nb_tk = mk(0,0,1, 3,0, 1,0, 1,1, 0,0,0, 0,0);   // branch, no hazard, taken
        alu1  = mk(0,0,1, 9,4, 1,1, 1,1, 1,0,4, 0,0);   // beq rt=4 after ALU op to $4, taken
        alu2  = mk(0,0,1, 9,4, 1,1, 1,1, 0,0,0, 0,4);   // same beq, result now past EX
        mx    = mk(0,0,1, 5,6, 1,1, 1,0, 1,1,5, 1,6);   // load in EX and load in MEM both hit

        rst = 1'b1;
        apply(mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0));
        repeat (2) @(posedge clk);

        vecs.push_back(mv(mk(1,0,1, 2,0, 1,0, 0,0, 1,1,2, 0,0), NONE, "reset_forces_zero"));
        vecs.push_back(mv(idle, NONE, "idle"));
        vecs.push_back(mv(lu, STL, "load_use_rs"));
        vecs.push_back(mv(mk(0,0,1, 8,2, 1,1, 0,0, 1,1,2, 0,0), STL, "load_use_rt"));
        vecs.push_back(mv(mk(0,0,1, 0,0, 1,0, 0,0, 1,1,0, 0,0), NONE, "zero_reg"));
        vecs.push_back(mv(mk(0,0,1, 8,2, 1,0, 0,0, 1,1,2, 0,0), NONE, "rt_unused"));
        vecs.push_back(mv(mk(0,0,0, 2,0, 1,0, 0,0, 1,1,2, 0,0), NONE, "id_invalid"));
        vecs.push_back(mv(mk(0,0,1, 2,0, 1,0, 0,0, 1,0,2, 0,0), NONE, "alu_fwd_nonbranch"));
        vecs.push_back(mv(mk(0,0,1, 2,0, 1,0, 0,0, 0,0,0, 1,2), NONE, "mem_load_nonbranch"));
        vecs.push_back(mv(mk(0,0,1, 4,0, 1,0, 1,0, 1,0,4, 0,0), STL, "branch_alu"));
        vecs.push_back(mv(mk(0,0,1, 4,0, 1,0, 1,0, 0,0,0, 1,4), STL, "branch_mem_load"));
        vecs.push_back(mv(mk(0,0,1, 4,0, 1,0, 1,0, 0,1,4, 0,0), NONE, "branch_no_regwrite"));
        vecs.push_back(mv(nb_tk, FLS, "branch_taken"));
        vecs.push_back(mv(nb_nt, NONE, "branch_not_taken"));
        vecs.push_back(mv(mk(0,0,1, 4,0, 1,0, 1,1, 1,0,4, 0,0), STL, "taken_ignored_on_hazard"));
        vecs.push_back(mv(mk(0,0,1, 4,4, 1,1, 1,0, 1,0,4, 1,4), STL, "two_n1_rules"));
        vecs.push_back(mv(idle, NONE, "after_two_n1"));
        vecs.push_back(mv(mk(0,1,1, 2,0, 1,0, 0,0, 1,1,2, 0,0), EXT, "ext_over_loaduse"));
        vecs.push_back(mv(mk(0,1,1, 3,0, 1,0, 1,1, 0,0,0, 0,0), EXT, "ext_over_taken"));
        vecs.push_back(mv(idle, NONE, "table_end"));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].s, vecs[i].e, vecs[i].nm);
        end

        // Branch after load: two bubbles; STALL ignores fresh inputs including a taken branch.
        step(bal,   STL,  "bal_c1");
        step(nb_tk, STL,  "bal_c2_in_stall");
        step(nb_nt, NONE, "bal_done");

        // Simultaneous n=2 and n=1 rules resolve to 2, not 3.
        step(mx,   STL,  "max_c1");
        step(mx,   STL,  "max_c2");
        step(idle, NONE, "max_done");

        // Branch after ALU op, then taken in the following RUN cycle.
        step(alu1, STL,  "alu_stall");
        step(alu2, FLS,  "alu_taken");
        step(idle, NONE, "alu_done");

        // ext_stall for 3 cycles inside a 2-cycle stall.
        begin
            stim_t bx;
            bx     = bal;
            bx.ext = 1'b1;
            step(bal,   STL,  "ext_c1");
            step(bx,    EXT,  "ext_f1");
            step(bx,    EXT,  "ext_f2");
            step(bx,    EXT,  "ext_f3");
            step(nb_nt, STL,  "ext_last_bubble");
            step(nb_nt, NONE, "ext_done");
        end

        // Preload stall_cnt near all-ones, then reset in the middle of STALL.
        step(mk(1,0,0, 0,0, 0,0, 0,0, 0,0,0, 0,0), NONE, "clr");
        for (int i = 0; i < MAX - 1; i++) step(lu, STL, "preload");
        step(bal, STL, "rst_stall_c1");
        step(mk(1,0,1, 3,0, 1,0, 1,0, 1,1,3, 0,0), NONE, "rst_in_stall");
        step(idle, NONE, "after_rst");
        step(lu,   STL,  "fresh_load_use");
        step(idle, NONE, "fresh_run");

        // Saturation of both counters.
        for (int i = 0; i < MAX + 1; i++) step(lu, STL, "stall_sat");
        for (int i = 0; i < MAX + 1; i++) step(nb_tk, FLS, "flush_sat");
        step(idle, NONE, "sat_check");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
